// File: rtl/store_write_buffer_pkg.sv
// Shared types for the store write buffer.
//   wb_entry_t : one buffered store (line address, lane-aligned data, byte enables)
//   wb_state_t : drain state machine encoding
//   WB_DEPTH   : default number of entries
package store_write_buffer_pkg;

    localparam int WB_DEPTH = 8;

    typedef logic [7:0] strobe_t;

    typedef struct packed {
        logic        valid;
        logic [60:0] addr;    // 8-byte line address (byte address [63:3])
        logic [63:0] data;
        strobe_t     strobe;
    } wb_entry_t;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_REQ  = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_forward_merge.sv
// Store-to-load forwarding for one lookup port.
//   entries_i   : registered buffer contents
//   head_i      : index of the oldest entry
//   lk_addr_i   : load byte address (only the line address is compared)
//   lk_data_o   : merged bytes from matching entries, zero where not supplied
//   lk_strobe_o : bytes supplied by the buffer
module wb_forward_merge
    import store_write_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wb_entry_t [DEPTH-1:0] entries_i,
    input  logic [PTR_W-1:0]      head_i,
    input  logic [63:0]           lk_addr_i,
    output logic [63:0]           lk_data_o,
    output strobe_t               lk_strobe_o
);

    logic unused_lk_lsbs;
    assign unused_lk_lsbs = ^lk_addr_i[2:0];

    // Walk oldest -> youngest so later writers overwrite earlier ones per byte.
    // Invalid slots are skipped, so walking all DEPTH slots from head is safe.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx         = '0;
        lk_data_o   = '0;
        lk_strobe_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_i + PTR_W'(i);
            if (entries_i[idx].valid && entries_i[idx].addr == lk_addr_i[63:3]) begin
                for (int b = 0; b < 8; b++) begin
                    if (entries_i[idx].strobe[b]) begin
                        lk_data_o[b*8 +: 8] = entries_i[idx].data[b*8 +: 8];
                        lk_strobe_o[b]      = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// In-order buffer of committed stores between the memory stage and the DBus.
//   clk_i, reset_i      : clock, synchronous active-high reset
//   push_*_i            : up to WRITE_WIDTH stores per cycle, slot 0 oldest
//   push_ready_o        : buffer can take WRITE_WIDTH stores this cycle
//   lk_addr_i           : READ_WIDTH load lookups
//   lk_data_o/strobe_o  : forwarded bytes from buffered stores
//   dreq_*_o            : drain request for the oldest entry
//   dresp_data_ok_i     : one-cycle pulse, outstanding write completed
//   empty_o             : nothing buffered and drain idle
module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter int DEPTH       = WB_DEPTH,
    parameter int WRITE_WIDTH = 2,
    parameter int READ_WIDTH  = 2
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [WRITE_WIDTH-1:0]       push_valid_i,
    input  logic [WRITE_WIDTH-1:0][63:0] push_addr_i,
    input  logic [WRITE_WIDTH-1:0][63:0] push_data_i,
    input  logic [WRITE_WIDTH-1:0][7:0]  push_strobe_i,
    output logic                         push_ready_o,
    input  logic [READ_WIDTH-1:0][63:0]  lk_addr_i,
    output logic [READ_WIDTH-1:0][63:0]  lk_data_o,
    output logic [READ_WIDTH-1:0][7:0]   lk_strobe_o,
    output logic                         dreq_valid_o,
    output logic [63:0]                  dreq_addr_o,
    output logic [63:0]                  dreq_data_o,
    output logic [7:0]                   dreq_strobe_o,
    input  logic                         dresp_data_ok_i,
    output logic                         empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    wb_state_t             state_q, state_d;

    logic [PTR_W-1:0]      wr_idx;
    logic [CNT_W-1:0]      n_push;
    logic                  pop;

    logic unused_addr_lsbs;
    always_comb begin
        unused_addr_lsbs = 1'b0;
        for (int s = 0; s < WRITE_WIDTH; s++) begin
            unused_addr_lsbs = unused_addr_lsbs ^ (^push_addr_i[s][2:0]);
        end
    end

    // Depends on registered count only, so callers see no combinational path
    // from their own push_valid.
    assign push_ready_o = (count_q <= CNT_W'(DEPTH - WRITE_WIDTH));
    assign empty_o      = (count_q == '0) && (state_q == WB_IDLE);

    assign dreq_addr_o   = {entries_q[head_q].addr, 3'b000};
    assign dreq_data_o   = entries_q[head_q].data;
    assign dreq_strobe_o = entries_q[head_q].strobe;

    always_comb begin
        entries_d    = entries_q;
        head_d       = head_q;
        state_d      = state_q;
        dreq_valid_o = 1'b0;
        pop          = 1'b0;
        wr_idx       = tail_q;
        n_push       = '0;

        case (state_q)
            WB_IDLE: begin
                if (count_q != '0) state_d = WB_REQ;
            end
            WB_REQ: begin
                dreq_valid_o = 1'b1;
                if (dresp_data_ok_i) begin
                    pop                     = 1'b1;
                    entries_d[head_q].valid = 1'b0;
                    head_d                  = head_q + 1'b1;
                    state_d                 = WB_IDLE;
                end
            end
            default: state_d = WB_IDLE;
        endcase

        // Compact valid slots in slot order starting at tail. With push_ready
        // set there are at least WRITE_WIDTH free slots, so a push never lands
        // on the head entry being popped in the same cycle.
        if (push_ready_o) begin
            for (int s = 0; s < WRITE_WIDTH; s++) begin
                if (push_valid_i[s]) begin
                    entries_d[wr_idx] = '{valid:  1'b1,
                                          addr:   push_addr_i[s][63:3],
                                          data:   push_data_i[s],
                                          strobe: push_strobe_i[s]};
                    wr_idx = wr_idx + 1'b1;
                    n_push = n_push + 1'b1;
                end
            end
        end

        tail_d  = wr_idx;
        count_d = count_q + n_push - {{(CNT_W-1){1'b0}}, pop};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            entries_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            state_q   <= WB_IDLE;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            state_q   <= state_d;
        end
    end

    for (genvar r = 0; r < READ_WIDTH; r++) begin : g_fwd
        wb_forward_merge #(.DEPTH(DEPTH)) u_fwd (
            .entries_i   (entries_q),
            .head_i      (head_q),
            .lk_addr_i   (lk_addr_i[r]),
            .lk_data_o   (lk_data_o[r]),
            .lk_strobe_o (lk_strobe_o[r])
        );
    end

endmodule

// File: tb/tb_store_write_buffer.sv
module tb_store_write_buffer;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       push_valid;
    logic [1:0][63:0] push_addr;
    logic [1:0][63:0] push_data;
    logic [1:0][7:0]  push_strobe;
    logic             push_ready;
    logic [1:0][63:0] lk_addr;
    logic [1:0][63:0] lk_data;
    logic [1:0][7:0]  lk_strobe;
    logic             dreq_valid;
    logic [63:0]      dreq_addr;
    logic [63:0]      dreq_data;
    logic [7:0]       dreq_strobe;
    logic             data_ok;
    logic             empty;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [60:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
    } ment_t;

    // Reference: the buffer is just an ordered list of stores, oldest first.
    ment_t q[$];

    store_write_buffer dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .push_valid_i    (push_valid),
        .push_addr_i     (push_addr),
        .push_data_i     (push_data),
        .push_strobe_i   (push_strobe),
        .push_ready_o    (push_ready),
        .lk_addr_i       (lk_addr),
        .lk_data_o       (lk_data),
        .lk_strobe_o     (lk_strobe),
        .dreq_valid_o    (dreq_valid),
        .dreq_addr_o     (dreq_addr),
        .dreq_data_o     (dreq_data),
        .dreq_strobe_o   (dreq_strobe),
        .dresp_data_ok_i (data_ok),
        .empty_o         (empty)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_push(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        ment_t e;
        e.addr = a[63:3];
        e.data = d;
        e.strb = s;
        q.push_back(e);
    endfunction

    function automatic void model_lookup(input logic [63:0] a, output logic [63:0] d, output logic [7:0] s);
        d = '0;
        s = '0;
        foreach (q[i]) begin
            if (q[i].addr == a[63:3]) begin
                for (int b = 0; b < 8; b++) begin
                    if (q[i].strb[b]) begin
                        d[b*8 +: 8] = q[i].data[b*8 +: 8];
                        s[b]        = 1'b1;
                    end
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        push_valid  = '0;
        push_addr   = '0;
        push_data   = '0;
        push_strobe = '0;
        lk_addr     = '0;
        data_ok     = 1'b0;
    endtask

    task automatic drive_slot(input int s, input logic [63:0] a, input logic [63:0] d, input logic [7:0] st);
        push_valid[s]  = 1'b1;
        push_addr[s]   = a;
        push_data[s]   = d;
        push_strobe[s] = st;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q.delete();
    endtask

    task automatic wait_dreq(input string tag);
        int n = 0;
        while (!dreq_valid && n < 20) begin
            tick();
            n++;
        end
        if (!dreq_valid) begin
            total++;
            bad++;
            $display("FAIL %s: dreq_valid timeout got=0 want=1", tag);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        #1;
        total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL reset_push_ready: got=%b want=1", push_ready); end
        total++; if (dreq_valid !== 1'b0) begin bad++; $display("FAIL reset_dreq_valid: got=%b want=0", dreq_valid); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got=%b want=1", empty); end
        total++; if (lk_strobe !== 16'h0) begin bad++; $display("FAIL reset_lk_strobe: got=%h want=0", lk_strobe); end
        reset = 1'b0;
        q.delete();
    endtask

    task automatic test_forward_basic();
        do_reset();
        drive_slot(0, 64'h8000_0010, 64'h1122334455667788, 8'hFF);
        tick();
        idle_inputs();
        lk_addr[0] = 64'h8000_0014;
        lk_addr[1] = 64'h8000_0018;
        #1;
        total++; if (lk_strobe[0] !== 8'hFF || lk_data[0] !== 64'h1122334455667788) begin
            bad++; $display("FAIL fwd_basic_hit: got strb=%h data=%h want strb=ff data=1122334455667788", lk_strobe[0], lk_data[0]);
        end
        total++; if (lk_strobe[1] !== 8'h00 || lk_data[1] !== 64'h0) begin
            bad++; $display("FAIL fwd_basic_miss: got strb=%h data=%h want 0/0", lk_strobe[1], lk_data[1]);
        end
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL fwd_basic_empty: got=%b want=0", empty); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        drive_slot(0, 64'h100, 64'hAA, 8'h01);
        drive_slot(1, 64'h100, 64'hBB00, 8'h03);
        tick();
        idle_inputs();
        lk_addr[0] = 64'h100;
        lk_addr[1] = 64'h104;
        #1;
        total++; if (lk_strobe[0] !== 8'h03 || lk_data[0] !== 64'hBB00) begin
            bad++; $display("FAIL same_cycle_merge: got strb=%h data=%h want strb=03 data=bb00", lk_strobe[0], lk_data[0]);
        end
        wait_dreq("same_cycle_first");
        total++; if (dreq_addr !== 64'h100 || dreq_data !== 64'hAA || dreq_strobe !== 8'h01) begin
            bad++; $display("FAIL same_cycle_drain0: got addr=%h data=%h strb=%h want 100/aa/01", dreq_addr, dreq_data, dreq_strobe);
        end
        data_ok = 1'b1;
        tick();
        data_ok = 1'b0;
        total++; if (dreq_valid !== 1'b0) begin bad++; $display("FAIL same_cycle_gap: dreq_valid got=%b want=0", dreq_valid); end
        wait_dreq("same_cycle_second");
        total++; if (dreq_addr !== 64'h100 || dreq_data !== 64'hBB00 || dreq_strobe !== 8'h03) begin
            bad++; $display("FAIL same_cycle_drain1: got addr=%h data=%h strb=%h want 100/bb00/03", dreq_addr, dreq_data, dreq_strobe);
        end
        data_ok = 1'b1;
        tick();
        data_ok = 1'b0;
        total++; if (empty !== 1'b1 || dreq_valid !== 1'b0) begin
            bad++; $display("FAIL same_cycle_empty: got empty=%b dreq_valid=%b want 1/0", empty, dreq_valid);
        end
    endtask

    task automatic test_full();
        logic [63:0] ed;
        logic [7:0]  es;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL full_ready_fill[%0d]: got=%b want=1", c, push_ready); end
            for (int s = 0; s < 2; s++) begin
                ed = {$urandom, $urandom};
                drive_slot(s, 64'h1000 + 64'(16*c + 8*s), ed, 8'hFF);
                model_push(64'h1000 + 64'(16*c + 8*s), ed, 8'hFF);
            end
            tick();
            idle_inputs();
        end
        total++; if (push_ready !== 1'b0) begin bad++; $display("FAIL full_ready_at8: got=%b want=0", push_ready); end
        // Held push while not ready must not be written.
        drive_slot(0, 64'h5000, 64'hDEAD, 8'hFF);
        tick();
        idle_inputs();
        lk_addr[0] = 64'h5000;
        lk_addr[1] = 64'h1000;
        #1;
        model_lookup(lk_addr[1], ed, es);
        total++; if (lk_strobe[0] !== 8'h00) begin bad++; $display("FAIL full_dropped_push: got strb=%h want 00", lk_strobe[0]); end
        total++; if (lk_strobe[1] !== es || lk_data[1] !== ed) begin
            bad++; $display("FAIL full_fwd: got strb=%h data=%h want strb=%h data=%h", lk_strobe[1], lk_data[1], es, ed);
        end
        for (int k = 0; k < 2; k++) begin
            wait_dreq("full_drain");
            total++; if (dreq_addr !== {q[0].addr, 3'b000} || dreq_data !== q[0].data) begin
                bad++; $display("FAIL full_drain[%0d]: got addr=%h data=%h want addr=%h data=%h", k, dreq_addr, dreq_data, {q[0].addr, 3'b000}, q[0].data);
            end
            data_ok = 1'b1;
            tick();
            data_ok = 1'b0;
            void'(q.pop_front());
            total++; if (push_ready !== (k == 1)) begin
                bad++; $display("FAIL full_ready_after_pop[%0d]: got=%b want=%b", k, push_ready, (k == 1));
            end
        end
    endtask

    task automatic test_slot1_only();
        logic [63:0] d1, d2, ed;
        logic [7:0]  es;
        do_reset();
        drive_slot(0, 64'h10, 64'h1010, 8'hFF); model_push(64'h10, 64'h1010, 8'hFF);
        drive_slot(1, 64'h18, 64'h1818, 8'hFF); model_push(64'h18, 64'h1818, 8'hFF);
        tick();
        idle_inputs();
        drive_slot(0, 64'h20, 64'h2020, 8'hFF); model_push(64'h20, 64'h2020, 8'hFF);
        tick();
        idle_inputs();
        // Slot 0 carries stale data with valid low.
        d1 = {$urandom, $urandom};
        push_addr[0] = 64'h208; push_data[0] = 64'hDEAD_BEEF; push_strobe[0] = 8'hFF;
        drive_slot(1, 64'h200, d1, 8'h0F); model_push(64'h200, d1, 8'h0F);
        tick();
        idle_inputs();
        d2 = {$urandom, $urandom};
        drive_slot(0, 64'h200, d2, 8'h3C); model_push(64'h200, d2, 8'h3C);
        tick();
        idle_inputs();
        lk_addr[0] = 64'h203;
        lk_addr[1] = 64'h208;
        #1;
        model_lookup(lk_addr[0], ed, es);
        total++; if (lk_strobe[0] !== es || lk_data[0] !== ed) begin
            bad++; $display("FAIL slot1_fwd: got strb=%h data=%h want strb=%h data=%h", lk_strobe[0], lk_data[0], es, ed);
        end
        total++; if (lk_strobe[1] !== 8'h00) begin bad++; $display("FAIL slot1_stale: got strb=%h want 00", lk_strobe[1]); end
        for (int k = 0; k < 5; k++) begin
            wait_dreq("slot1_drain");
            total++; if (dreq_addr !== {q[0].addr, 3'b000} || dreq_data !== q[0].data || dreq_strobe !== q[0].strb) begin
                bad++; $display("FAIL slot1_drain[%0d]: got addr=%h data=%h strb=%h want addr=%h data=%h strb=%h",
                                k, dreq_addr, dreq_data, dreq_strobe, {q[0].addr, 3'b000}, q[0].data, q[0].strb);
            end
            data_ok = 1'b1;
            tick();
            data_ok = 1'b0;
            void'(q.pop_front());
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL slot1_empty: got=%b want=1", empty); end
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        drive_slot(0, 64'h300, 64'h3333, 8'hFF);
        tick();
        idle_inputs();
        wait_dreq("reset_mid_req");
        total++; if (dreq_addr !== 64'h300) begin bad++; $display("FAIL reset_mid_req_addr: got=%h want=300", dreq_addr); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q.delete();
        lk_addr[0] = 64'h300;
        #1;
        total++; if (dreq_valid !== 1'b0 || empty !== 1'b1) begin
            bad++; $display("FAIL reset_mid_req_state: got dreq_valid=%b empty=%b want 0/1", dreq_valid, empty);
        end
        total++; if (lk_strobe[0] !== 8'h00) begin bad++; $display("FAIL reset_mid_req_fwd: got strb=%h want 00", lk_strobe[0]); end
        tick();
        total++; if (dreq_valid !== 1'b0) begin bad++; $display("FAIL reset_mid_req_stays_idle: got=%b want=0", dreq_valid); end
    endtask

    task automatic test_random_wrap();
        int pushed = 0;
        int cyc = 0;
        int delay = 0;
        int nv;
        bit waiting = 1'b0;
        bit rdy;
        logic [63:0] ed;
        logic [7:0]  es;
        do_reset();
        while ((pushed < 20 || q.size() != 0) && cyc < 2000) begin
            idle_inputs();
            nv = 0;
            for (int s = 0; s < 2; s++) begin
                if (pushed + nv < 20 && $urandom_range(0, 1) == 1) begin
                    drive_slot(s, 64'h400 + 64'(8 * $urandom_range(0, 2)) + 64'($urandom_range(0, 7)),
                               {$urandom, $urandom}, 8'($urandom_range(1, 255)));
                    nv++;
                end
            end
            for (int r = 0; r < 2; r++) lk_addr[r] = 64'h400 + 64'(8 * $urandom_range(0, 3));
            if (dreq_valid) begin
                if (!waiting) begin
                    waiting = 1'b1;
                    delay = $urandom_range(0, 5);
                end
                if (delay == 0) begin
                    data_ok = 1'b1;
                    waiting = 1'b0;
                end else begin
                    delay--;
                end
            end
            #1;
            rdy = (q.size() <= 6);
            total++; if (push_ready !== rdy) begin bad++; $display("FAIL wrap_ready[c%0d]: got=%b want=%b (entries=%0d)", cyc, push_ready, rdy, q.size()); end
            for (int r = 0; r < 2; r++) begin
                model_lookup(lk_addr[r], ed, es);
                total++; if (lk_strobe[r] !== es || lk_data[r] !== ed) begin
                    bad++; $display("FAIL wrap_fwd[c%0d p%0d]: got strb=%h data=%h want strb=%h data=%h", cyc, r, lk_strobe[r], lk_data[r], es, ed);
                end
            end
            if (dreq_valid) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL wrap_dreq_when_empty[c%0d]: got dreq_valid=1 want 0", cyc);
                end else if (dreq_addr !== {q[0].addr, 3'b000} || dreq_data !== q[0].data || dreq_strobe !== q[0].strb) begin
                    bad++; $display("FAIL wrap_order[c%0d]: got addr=%h data=%h strb=%h want addr=%h data=%h strb=%h",
                                    cyc, dreq_addr, dreq_data, dreq_strobe, {q[0].addr, 3'b000}, q[0].data, q[0].strb);
                end
            end
            if (data_ok && q.size() != 0) void'(q.pop_front());
            if (rdy) begin
                for (int s = 0; s < 2; s++) begin
                    if (push_valid[s]) begin
                        model_push(push_addr[s], push_data[s], push_strobe[s]);
                        pushed++;
                    end
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        total++; if (cyc >= 2000) begin bad++; $display("FAIL wrap_timeout: got cycles=%0d want <2000", cyc); end
        idle_inputs();
        #1;
        total++; if (empty !== 1'b1 || dreq_valid !== 1'b0) begin
            bad++; $display("FAIL wrap_final_empty: got empty=%b dreq_valid=%b want 1/0", empty, dreq_valid);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_forward_basic();
        test_same_cycle();
        test_full();
        test_slot1_only();
        test_reset_mid_req();
        test_random_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
